dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port 256×64 data memory. It shares the memory between the CPU load/store stage (port 0) and the debug/loader port (port 1). Each request is latched, the memory strobes are driven for exactly one cycle, and the result is returned with a one-cycle valid pulse. It sits between the requesters and the data memory's `MemRead`/`MemWrite`/`addr`/`write_data`/`read_data` pins.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W        = 64;
  localparam int unsigned DATA_W        = 64;
  localparam int unsigned WORD_OFFSET_W = 3;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              p0_req,    p1_req;
  logic              p0_we,     p1_we;
  logic [ADDR_W-1:0] p0_addr,   p1_addr;
  logic [DATA_W-1:0] p0_wdata,  p1_wdata;
  logic              p0_gnt,    p1_gnt;
  logic              p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata,  p1_rdata;
  logic              p0_err,    p1_err;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus the memory device.
  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_err, p1_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

  // The arbiter itself.
  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_err, p1_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; owns the last-served pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_pick_c
);

  logic r_last;  // 1 = port 1 was served last

  always_comb begin
    o_pick_c = i_req;
    if (&i_req) o_pick_c = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_last <= 1'b1;
    else if (i_advance && |i_req) r_last <= o_pick_c[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port 256x64 data memory.
// Define DMEM_ARB_ALIGN_CHK_EN to suppress and flag misaligned accesses.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_take;
  logic              w_mis;
  logic [1:0]        w_req;
  logic [1:0]        w_pick;
  logic              w_gnt0, w_gnt1, w_rv0, w_rv1;

  logic              r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  assign w_req = {bus.p1_req, bus.p0_req};

  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_advance (w_take),
    .o_pick_c  (w_pick)
  );

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign w_mis = |r_addr[WORD_OFFSET_W-1:0];
`else
  assign w_mis = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; RESP chains straight into ACCESS when a request is pending.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_take      = |w_req;
        w_state_nxt = w_take ? ACCESS : IDLE;
      end
      ACCESS: w_state_nxt = RESP;
      RESP: begin
        w_take      = |w_req;
        w_state_nxt = w_take ? ACCESS : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch for the arbitration winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_port  <= PORT0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_port  <= w_pick[1] ? PORT1 : PORT0;
      r_we    <= w_pick[1] ? bus.p1_we    : bus.p0_we;
      r_addr  <= w_pick[1] ? bus.p1_addr  : bus.p0_addr;
      r_wdata <= w_pick[1] ? bus.p1_wdata : bus.p0_wdata;
    end
  end

  // Response capture at the closing edge of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_rdata <= (r_we || w_mis) ? '0 : bus.mem_rdata;
      r_err   <= w_mis;
    end
  end

  // Strobes decode from state only, so reset drops them immediately.
  assign w_gnt0 = (r_state == ACCESS) && (r_port == PORT0);
  assign w_gnt1 = (r_state == ACCESS) && (r_port == PORT1);
  assign w_rv0  = (r_state == RESP)   && (r_port == PORT0);
  assign w_rv1  = (r_state == RESP)   && (r_port == PORT1);

  assign bus.p0_gnt    = w_gnt0;
  assign bus.p1_gnt    = w_gnt1;
  assign bus.p0_rvalid = w_rv0;
  assign bus.p1_rvalid = w_rv1;
  assign bus.p0_rdata  = w_rv0 ? r_rdata : '0;
  assign bus.p1_rdata  = w_rv1 ? r_rdata : '0;
  assign bus.p0_err    = w_rv0 & r_err;
  assign bus.p1_err    = w_rv1 & r_err;

  assign bus.mem_read  = (r_state == ACCESS) && !r_we && !w_mis;
  assign bus.mem_write = (r_state == ACCESS) &&  r_we && !w_mis;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level reference model plus memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Memory device and the model's own view of its contents.
  logic [63:0] mem     [256];
  logic [63:0] ref_mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr[10:3]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[10:3]] <= bus.mem_wdata;

  typedef struct { int gap; logic we; logic [63:0] addr; logic [63:0] wdata; } stim_t;
  typedef struct { int port; int cyc; logic [63:0] addr; logic [63:0] wdata; logic we; logic mis; } gexp_t;
  typedef struct { int port; int cyc; logic [63:0] rdata; logic err; } rexp_t;

  stim_t sq0[$], sq1[$];
  gexp_t exp_g[$];
  rexp_t exp_r[$];
  int    glog_port[$], glog_cyc[$];

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, next_free = 0, rvalid_seen = 0;
  logic last = 1'b1;
  logic pend_v = 1'b0;
  logic [7:0]  pend_idx = '0;
  logic [63:0] pend_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic stim_t mk(input int gap, input logic we, input logic [63:0] a, input logic [63:0] d);
    stim_t s;
    s.gap = gap; s.we = we; s.addr = a; s.wdata = d;
    return s;
  endfunction

  // Reference model: one transaction every two cycles once free, round-robin on ties.
  always @(posedge clk or posedge rst) begin : model
    int          win;
    logic [63:0] a, d, rd;
    logic        w, m;
    gexp_t       ge;
    rexp_t       re;
    if (rst) begin
      exp_g.delete();
      exp_r.delete();
      pend_v    <= 1'b0;
      last      <= 1'b1;
      next_free <= 0;
    end else begin
      if (pend_v) ref_mem[pend_idx] <= pend_data;
      pend_v <= 1'b0;
      if (cyc >= next_free && (bus.p0_req || bus.p1_req)) begin
        if (bus.p0_req && bus.p1_req) win = last ? 0 : 1;
        else                          win = bus.p1_req ? 1 : 0;
        w  = (win == 1) ? bus.p1_we    : bus.p0_we;
        a  = (win == 1) ? bus.p1_addr  : bus.p0_addr;
        d  = (win == 1) ? bus.p1_wdata : bus.p0_wdata;
        m  = ALIGN && (a[2:0] != 3'd0);
        rd = (w || m) ? 64'h0 : ref_mem[a[10:3]];
        ge.port = win; ge.cyc = cyc + 1; ge.addr = a; ge.wdata = d; ge.we = w; ge.mis = m;
        re.port = win; re.cyc = cyc + 2; re.rdata = rd; re.err = m;
        exp_g.push_back(ge);
        exp_r.push_back(re);
        if (w && !m) begin
          pend_v    <= 1'b1;
          pend_idx  <= a[10:3];
          pend_data <= d;
        end
        last      <= (win == 1);
        next_free <= cyc + 2;
      end
      cyc <= cyc + 1;
    end
  end

  // Monitor: pops expected grants/responses whenever the DUT presents one.
  always @(negedge clk) begin : mon
    gexp_t g;
    rexp_t r;
    logic [1:0] gv, rv;
    if (!rst) begin
      gv = {bus.p1_gnt, bus.p0_gnt};
      if (gv != 2'b00) begin
        if (exp_g.size() == 0) chk("gnt_unexpected", 64'(gv), 64'h0);
        else begin
          g = exp_g.pop_front();
          chk("gnt_port",  64'(gv), 64'(2'b01 << g.port));
          chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
          chk("mem_addr",  bus.mem_addr, g.addr);
          chk("mem_write", 64'(bus.mem_write), 64'(g.we && !g.mis));
          chk("mem_read",  64'(bus.mem_read),  64'(!g.we && !g.mis));
          if (g.we) chk("mem_wdata", bus.mem_wdata, g.wdata);
          glog_port.push_back(g.port);
          glog_cyc.push_back(cyc);
        end
      end else begin
        if (exp_g.size() > 0 && exp_g[0].cyc <= cyc) begin
          g = exp_g.pop_front();
          chk("gnt_missing", 64'h0, 64'(2'b01 << g.port));
        end
        chk("idle_strobes", 64'({bus.mem_read, bus.mem_write}), 64'h0);
      end

      rv = {bus.p1_rvalid, bus.p0_rvalid};
      if (rv != 2'b00) begin
        rvalid_seen++;
        if (exp_r.size() == 0) chk("rvalid_unexpected", 64'(rv), 64'h0);
        else begin
          r = exp_r.pop_front();
          chk("rvalid_port",  64'(rv), 64'(2'b01 << r.port));
          chk("rvalid_cycle", 64'(cyc), 64'(r.cyc));
          chk("rdata", (r.port == 1) ? bus.p1_rdata : bus.p0_rdata, r.rdata);
          chk("err",   64'({bus.p1_err, bus.p0_err}), 64'(2'(r.err) << r.port));
        end
      end else if (exp_r.size() > 0 && exp_r[0].cyc <= cyc) begin
        r = exp_r.pop_front();
        chk("rvalid_missing", 64'h0, 64'(2'b01 << r.port));
      end
    end else if (bus.p0_rvalid || bus.p1_rvalid) begin
      rvalid_seen++;
    end
  end

  // Port drivers: present next queued request after its gap, drop req once gnt is seen.
  initial begin : drv
    stim_t s;
    int gap0, gap1;
    gap0 = 0; gap1 = 0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.p0_req = 1'b0; bus.p1_req = 1'b0; gap0 = 0; gap1 = 0;
      end else begin
        if (bus.p0_req && bus.p0_gnt) bus.p0_req = 1'b0;
        if (!bus.p0_req && sq0.size() > 0) begin
          if (gap0 < sq0[0].gap) gap0++;
          else begin
            s = sq0.pop_front();
            bus.p0_we = s.we; bus.p0_addr = s.addr; bus.p0_wdata = s.wdata;
            bus.p0_req = 1'b1; gap0 = 0;
          end
        end
        if (bus.p1_req && bus.p1_gnt) bus.p1_req = 1'b0;
        if (!bus.p1_req && sq1.size() > 0) begin
          if (gap1 < sq1[0].gap) gap1++;
          else begin
            s = sq1.pop_front();
            bus.p1_we = s.we; bus.p1_addr = s.addr; bus.p1_wdata = s.wdata;
            bus.p1_req = 1'b1; gap1 = 0;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 || bus.p0_req || bus.p1_req ||
            exp_g.size() > 0 || exp_r.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n >= budget), 64'h0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] a;
    a = 64'($urandom_range(0, 511)) << 3;
    if ($urandom_range(0, 7) == 0) a = a | 64'($urandom_range(1, 7));
    if ($urandom_range(0, 7) == 0) a[40] = 1'b1;
    return a;
  endfunction

  initial begin : main
    logic [63:0] v, old3;
    int n, seen0;
    for (int i = 0; i < 256; i++) begin
      v = {$urandom(), $urandom()};
      if (i == 0) v = 64'd5;
      if (i == 2) v = 64'h1111;
      mem[i]     <= v;
      ref_mem[i] <= v;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while idle: every output returns to zero.
    #1 rst = 1'b1;
    #1;
    chk("rst_p0_gnt",    64'(bus.p0_gnt),    64'h0);
    chk("rst_p1_gnt",    64'(bus.p1_gnt),    64'h0);
    chk("rst_p0_rvalid", 64'(bus.p0_rvalid), 64'h0);
    chk("rst_p1_rvalid", 64'(bus.p1_rvalid), 64'h0);
    chk("rst_p0_err",    64'(bus.p0_err),    64'h0);
    chk("rst_p1_err",    64'(bus.p1_err),    64'h0);
    chk("rst_p0_rdata",  bus.p0_rdata,       64'h0);
    chk("rst_p1_rdata",  bus.p1_rdata,       64'h0);
    chk("rst_mem_read",  64'(bus.mem_read),  64'h0);
    chk("rst_mem_write", 64'(bus.mem_write), 64'h0);
    chk("rst_mem_addr",  bus.mem_addr,       64'h0);
    chk("rst_mem_wdata", bus.mem_wdata,      64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: both ports held busy for two requests each.
    glog_port.delete(); glog_cyc.delete();
    sq0.push_back(mk(0, 1'b0, 64'h20, 64'h0));
    sq0.push_back(mk(0, 1'b0, 64'h28, 64'h0));
    sq1.push_back(mk(0, 1'b1, 64'h30, 64'hC0FFEE));
    sq1.push_back(mk(0, 1'b0, 64'h38, 64'h0));
    wait_idle(100);
    chk("cont_count", 64'(glog_port.size()), 64'd4);
    if (glog_port.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cont_order", 64'(glog_port[i]), 64'(i % 2));
        if (i > 0) chk("cont_spacing", 64'(glog_cyc[i] - glog_cyc[i-1]), 64'd2);
      end
    end

    // Read of preloaded word 0.
    sq0.push_back(mk(0, 1'b0, 64'h0, 64'h0));
    wait_idle(50);

    // Write on port 1 then read back on port 0.
    sq1.push_back(mk(0, 1'b1, 64'h10, 64'hDEADBEEF));
    wait_idle(50);
    sq0.push_back(mk(0, 1'b0, 64'h10, 64'h0));
    wait_idle(50);
    chk("wr_word2", mem[2], 64'hDEADBEEF);

    // Misaligned write to 0x13 lands on word 2 only without the check.
    sq0.push_back(mk(0, 1'b1, 64'h13, 64'h55));
    wait_idle(50);
    chk("misalign_word2", mem[2], ALIGN ? 64'hDEADBEEF : 64'h55);

    // Randomized traffic on both ports.
    for (int i = 0; i < 60; i++) begin
      sq0.push_back(mk($urandom_range(0, 3), 1'($urandom_range(0, 1)), rnd_addr(), {$urandom(), $urandom()}));
      sq1.push_back(mk($urandom_range(0, 3), 1'($urandom_range(0, 1)), rnd_addr(), {$urandom(), $urandom()}));
    end
    wait_idle(2000);

    // Reset during the ACCESS cycle of a write to 0x18.
    old3 = ref_mem[3];
    sq1.push_back(mk(0, 1'b1, 64'h18, 64'hA5A5_5A5A_0F0F_F0F0));
    n = 0;
    while (!bus.p1_gnt && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_gnt_wait", 64'(n < 50), 64'h1);
    seen0 = rvalid_seen;
    #1 rst = 1'b1;
    #1;
    chk("rst_access_mem_write", 64'(bus.mem_write), 64'h0);
    chk("rst_access_mem_read",  64'(bus.mem_read),  64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_no_rvalid", 64'(rvalid_seen), 64'(seen0));
    chk("rst_word3", mem[3], old3);

    for (int i = 0; i < 256; i++) chk("mem_word", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
